uart_alu_frame_ctrl: RTL and testbench

//  Framed command controller between the UART FIFOs and a combinational ALU.
//  - Parses frames of START, OPCODE, operand A, operand B and an XOR checksum from the RX FIFO.
//  - Operands are multi-byte.
//  - Drives the ALU, then returns a status byte plus the result bytes through the TX FIFO.
//  - Adds byte-level flow control, frame validation and an inter-byte timeout, which the single-byte interface lacks.

---
 rtl/uart_alu_frame_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_uart_alu_frame_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_alu_frame_ctrl.sv
// Framed command controller: pulls START/OPCODE/A/B/checksum frames from the RX FIFO,
// drives a combinational ALU and returns a status byte plus result bytes through the TX FIFO.
module uart_alu_frame_ctrl #(
    parameter int                   DATA_BITS      = 8,
    parameter int                   OP_BYTES       = 2,
    parameter int                   OPCODE_BITS    = 6,
    parameter logic [DATA_BITS-1:0] START_BYTE     = 8'hA5,
    parameter int                   TIMEOUT_CYCLES = 100000,
    parameter int                   TMR_W          = 17,
    localparam int                  OPW            = OP_BYTES * DATA_BITS
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_rx_empty,
    input  logic [DATA_BITS-1:0]   i_r_data,
    output logic                   o_rd_uart,
    input  logic                   i_tx_full,
    output logic [DATA_BITS-1:0]   o_w_data,
    output logic                   o_wr_uart,
    output logic [OPW-1:0]         o_op_a,
    output logic [OPW-1:0]         o_op_b,
    output logic [OPCODE_BITS-1:0] o_op_code,
    input  logic [OPW-1:0]         i_alu_result,
    output logic                   o_busy,
    output logic                   o_frame_err
);

    localparam int IDX_W = (OP_BYTES > 1) ? $clog2(OP_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OP_BYTES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        OPC,
        OPA,
        OPB,
        CHK,
        EXEC,
        SEND_STAT,
        SEND_RES
    } state_t;

    state_t                 state_q;
    logic [DATA_BITS-1:0]   chkSum_q;
    logic [DATA_BITS-1:0]   status_q;
    logic [TMR_W-1:0]       timer_q;
    logic [IDX_W-1:0]       byteIdx_q;
    logic [OPW-1:0]         result_q;
    logic [OPW-1:0]         opA_q;
    logic [OPW-1:0]         opB_q;
    logic [OPCODE_BITS-1:0] opCode_q;
    logic                   chkBad_q;
    logic                   opcHigh_q;

    logic                   inFrame;
    logic                   popByte;
    logic                   pushByte;
    logic                   timeoutHit;
    logic [DATA_BITS-1:0]   wrData_d;

    // Handshake strobes are decoded from the current state so a byte is taken or
    // offered in the very cycle the FIFO flag allows it; reset blocks both.
    always_comb begin
        inFrame    = (state_q == OPC) || (state_q == OPA) || (state_q == OPB) || (state_q == CHK);
        popByte    = (inFrame || state_q == IDLE) && !i_rx_empty && !i_reset;
        pushByte   = (state_q == SEND_STAT || state_q == SEND_RES) && !i_tx_full && !i_reset;
        timeoutHit = inFrame && !popByte && (timer_q == TMR_LAST);
        wrData_d   = '0;
        if (state_q == SEND_STAT) begin
            wrData_d = status_q;
        end else if (state_q == SEND_RES) begin
            wrData_d = result_q[int'(byteIdx_q) * DATA_BITS +: DATA_BITS];
        end
    end

    assign o_rd_uart   = popByte;
    assign o_wr_uart   = pushByte;
    assign o_w_data    = pushByte ? wrData_d : '0;
    assign o_frame_err = pushByte && (state_q == SEND_STAT) && (status_q != '0);
    assign o_busy      = (state_q != IDLE);
    assign o_op_a      = opA_q;
    assign o_op_b      = opB_q;
    assign o_op_code   = opCode_q;

    // Frame sequencer; a timeout anywhere between OPC and CHK jumps straight to
    // reporting status 03 and drops the partial frame.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= IDLE;
            chkSum_q  <= '0;
            status_q  <= '0;
            timer_q   <= '0;
            byteIdx_q <= '0;
            result_q  <= '0;
            opA_q     <= '0;
            opB_q     <= '0;
            opCode_q  <= '0;
            chkBad_q  <= 1'b0;
            opcHigh_q <= 1'b0;
        end else begin
            if (inFrame) begin
                timer_q <= popByte ? '0 : timer_q + TMR_W'(1);
            end

            case (state_q)
                IDLE: begin
                    if (popByte && i_r_data == START_BYTE) begin
                        chkSum_q  <= '0;
                        timer_q   <= '0;
                        byteIdx_q <= '0;
                        state_q   <= OPC;
                    end
                end

                OPC: begin
                    if (popByte) begin
                        opCode_q  <= i_r_data[OPCODE_BITS-1:0];
                        opcHigh_q <= (i_r_data >> OPCODE_BITS) != '0;
                        chkSum_q  <= chkSum_q ^ i_r_data;
                        byteIdx_q <= '0;
                        state_q   <= OPA;
                    end else if (timeoutHit) begin
                        status_q <= DATA_BITS'(3);
                        state_q  <= SEND_STAT;
                    end
                end

                OPA: begin
                    if (popByte) begin
                        opA_q[int'(byteIdx_q) * DATA_BITS +: DATA_BITS] <= i_r_data;
                        chkSum_q <= chkSum_q ^ i_r_data;
                        if (byteIdx_q == LAST_IDX) begin
                            byteIdx_q <= '0;
                            state_q   <= OPB;
                        end else begin
                            byteIdx_q <= byteIdx_q + IDX_W'(1);
                        end
                    end else if (timeoutHit) begin
                        status_q <= DATA_BITS'(3);
                        state_q  <= SEND_STAT;
                    end
                end

                OPB: begin
                    if (popByte) begin
                        opB_q[int'(byteIdx_q) * DATA_BITS +: DATA_BITS] <= i_r_data;
                        chkSum_q <= chkSum_q ^ i_r_data;
                        if (byteIdx_q == LAST_IDX) begin
                            byteIdx_q <= '0;
                            state_q   <= CHK;
                        end else begin
                            byteIdx_q <= byteIdx_q + IDX_W'(1);
                        end
                    end else if (timeoutHit) begin
                        status_q <= DATA_BITS'(3);
                        state_q  <= SEND_STAT;
                    end
                end

                CHK: begin
                    if (popByte) begin
                        chkBad_q <= (i_r_data != chkSum_q);
                        state_q  <= EXEC;
                    end else if (timeoutHit) begin
                        status_q <= DATA_BITS'(3);
                        state_q  <= SEND_STAT;
                    end
                end

                // A corrupted frame outranks an illegal opcode in the reported status.
                EXEC: begin
                    result_q  <= i_alu_result;
                    status_q  <= chkBad_q ? DATA_BITS'(1) : (opcHigh_q ? DATA_BITS'(2) : '0);
                    byteIdx_q <= '0;
                    state_q   <= SEND_STAT;
                end

                SEND_STAT: begin
                    if (pushByte) begin
                        byteIdx_q <= '0;
                        state_q   <= (status_q == '0) ? SEND_RES : IDLE;
                    end
                end

                SEND_RES: begin
                    if (pushByte) begin
                        if (byteIdx_q == LAST_IDX) begin
                            byteIdx_q <= '0;
                            state_q   <= IDLE;
                        end else begin
                            byteIdx_q <= byteIdx_q + IDX_W'(1);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_frame_ctrl.sv
// Self-checking bench for uart_alu_frame_ctrl: queue-based RX/TX FIFO models, a small
// ALU, a vector table, randomized frames against a frame-level reference, and corner sequences.
module tb_uart_alu_frame_ctrl;

    localparam int TIMEOUT_CYCLES = 200;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_rx_empty = 1'b1;
    logic [7:0]  i_r_data = 8'h00;
    logic        i_tx_full = 1'b0;
    logic        o_rd_uart;
    logic [7:0]  o_w_data;
    logic        o_wr_uart;
    logic [15:0] o_op_a;
    logic [15:0] o_op_b;
    logic [5:0]  o_op_code;
    logic [15:0] i_alu_result;
    logic        o_busy;
    logic        o_frame_err;

    logic [7:0]  rxQ[$];
    logic [7:0]  txQ[$];
    int          ferrCount = 0;
    int          rdCount = 0;
    int          checks = 0;
    int          failures = 0;
    logic        randFull = 1'b0;

    typedef struct {
        logic [7:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  chkFlip;
        logic [7:0]  expStatus;
        logic [15:0] expResult;
    } vec_t;

    vec_t vecs[7];

    uart_alu_frame_ctrl #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_rx_empty   (i_rx_empty),
        .i_r_data     (i_r_data),
        .o_rd_uart    (o_rd_uart),
        .i_tx_full    (i_tx_full),
        .o_w_data     (o_w_data),
        .o_wr_uart    (o_wr_uart),
        .o_op_a       (o_op_a),
        .o_op_b       (o_op_b),
        .o_op_code    (o_op_code),
        .i_alu_result (i_alu_result),
        .o_busy       (o_busy),
        .o_frame_err  (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    // ALU stand-in: 0x20 add, 0x21 subtract, anything else XOR.
    function automatic logic [15:0] aluModel(input logic [5:0] opc, input logic [15:0] a, input logic [15:0] b);
        case (opc)
            6'h20:   return a + b;
            6'h21:   return a - b;
            default: return a ^ b;
        endcase
    endfunction

    always_comb i_alu_result = aluModel(o_op_code, o_op_a, o_op_b);

    // FIFO models: transfers commit on the rising edge, the RX head is refreshed on the falling edge.
    always @(posedge i_clk) begin
        if (o_rd_uart) begin
            if (rxQ.size() > 0) void'(rxQ.pop_front());
            rdCount++;
        end
        if (o_wr_uart) txQ.push_back(o_w_data);
        if (o_frame_err) ferrCount++;
    end

    always @(negedge i_clk) begin
        i_rx_empty = (rxQ.size() == 0);
        i_r_data   = (rxQ.size() > 0) ? rxQ[0] : 8'h00;
    end

    function automatic logic [31:0] txAt(input int i);
        return (i < txQ.size()) ? {24'h0, txQ[i]} : 32'hFFFF_FFFF;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushFrame(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] b, input logic [7:0] chkFlip);
        logic [7:0] chk;
        chk = opc ^ a[7:0] ^ a[15:8] ^ b[7:0] ^ b[15:8];
        rxQ.push_back(8'hA5);
        rxQ.push_back(opc);
        rxQ.push_back(a[7:0]);
        rxQ.push_back(a[15:8]);
        rxQ.push_back(b[7:0]);
        rxQ.push_back(b[15:8]);
        rxQ.push_back(chk ^ chkFlip);
    endtask

    task automatic waitDone(input int n, input string tag);
        int cyc;
        cyc = 0;
        while ((txQ.size() < n || o_busy || rxQ.size() > 0) && cyc < 600) begin
            @(negedge i_clk);
            if (randFull) i_tx_full = ($urandom_range(0, 2) == 0);
            cyc++;
        end
        i_tx_full = 1'b0;
        repeat (5) @(negedge i_clk);
        checkOutput({tag, ".idle"}, {31'b0, o_busy}, 32'd0);
    endtask

    // Sends one frame and compares the whole TX response plus the latched ALU operands.
    task automatic applyStimulus(input logic [7:0] opc, input logic [15:0] a, input logic [15:0] b,
                                 input logic [7:0] chkFlip, input logic [7:0] expStatus,
                                 input logic [15:0] expResult, input string tag);
        int expLen;
        int f0;
        expLen = (expStatus == 8'h00) ? 3 : 1;
        txQ.delete();
        f0 = ferrCount;
        pushFrame(opc, a, b, chkFlip);
        waitDone(expLen, tag);
        checkOutput({tag, ".len"}, txQ.size(), expLen);
        checkOutput({tag, ".status"}, txAt(0), {24'h0, expStatus});
        checkOutput({tag, ".ferr"}, ferrCount - f0, (expStatus != 8'h00) ? 1 : 0);
        checkOutput({tag, ".opA"}, {16'h0, o_op_a}, {16'h0, a});
        checkOutput({tag, ".opB"}, {16'h0, o_op_b}, {16'h0, b});
        checkOutput({tag, ".opc"}, {26'h0, o_op_code}, {26'h0, opc[5:0]});
        if (expStatus == 8'h00) begin
            checkOutput({tag, ".resLo"}, txAt(1), {24'h0, expResult[7:0]});
            checkOutput({tag, ".resHi"}, txAt(2), {24'h0, expResult[15:8]});
        end
    endtask

    initial begin
        int cyc;
        int f0;
        int r0;
        int wrSeen;
        logic [7:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic [7:0]  flip;
        logic [7:0]  st;

        vecs[0] = '{8'h20, 16'h1234, 16'h0010, 8'h00, 8'h00, 16'h1244};
        vecs[1] = '{8'h20, 16'h1234, 16'h0010, 8'h01, 8'h01, 16'h0000};
        vecs[2] = '{8'hE0, 16'h0001, 16'h0001, 8'h00, 8'h02, 16'h0000};
        vecs[3] = '{8'h21, 16'h0010, 16'h0020, 8'h00, 8'h00, 16'hFFF0};
        vecs[4] = '{8'h20, 16'hFFFF, 16'h0001, 8'h00, 8'h00, 16'h0000};
        vecs[5] = '{8'h3F, 16'h00A5, 16'hA5A5, 8'h00, 8'h00, 16'hA500};
        vecs[6] = '{8'h60, 16'h0102, 16'h0304, 8'h80, 8'h01, 16'h0000};

        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("reset.busy", {31'b0, o_busy}, 32'd0);
        checkOutput("reset.opA", {16'h0, o_op_a}, 32'd0);
        checkOutput("reset.opB", {16'h0, o_op_b}, 32'd0);
        checkOutput("reset.opc", {26'h0, o_op_code}, 32'd0);
        checkOutput("reset.wr", {31'b0, o_wr_uart}, 32'd0);
        checkOutput("reset.wdata", {24'h0, o_w_data}, 32'd0);
        checkOutput("reset.ferr", {31'b0, o_frame_err}, 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].chkFlip,
                          vecs[i].expStatus, vecs[i].expResult, $sformatf("vec%0d", i));
        end

        // Randomized frames with a stuttering TX FIFO; expectations come from frame-level rules.
        randFull = 1'b1;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0:       opc = 8'h20;
                1:       opc = 8'h21;
                2:       opc = 8'($urandom_range(0, 255));
                default: opc = 8'($urandom_range(0, 63));
            endcase
            a    = 16'($urandom_range(0, 65535));
            b    = 16'($urandom_range(0, 65535));
            flip = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            st   = (flip != 8'h00) ? 8'h01 : ((opc[7:6] != 2'b00) ? 8'h02 : 8'h00);
            applyStimulus(opc, a, b, flip, st, aluModel(opc[5:0], a, b), $sformatf("rand%0d", i));
        end
        randFull = 1'b0;

        // Junk before START, then the frame stalls after its opcode.
        txQ.delete();
        f0 = ferrCount;
        r0 = rdCount;
        rxQ.push_back(8'h00);
        rxQ.push_back(8'hFF);
        rxQ.push_back(8'hA5);
        rxQ.push_back(8'h20);
        cyc = 0;
        while (rxQ.size() > 0 && cyc < 50) begin
            @(negedge i_clk);
            cyc++;
        end
        cyc = 0;
        while (txQ.size() == 0 && cyc < TIMEOUT_CYCLES + 50) begin
            @(negedge i_clk);
            cyc++;
        end
        checkOutput("tmo.window", {31'b0, (cyc >= TIMEOUT_CYCLES - 2) && (cyc <= TIMEOUT_CYCLES + 3)}, 32'd1);
        repeat (5) @(negedge i_clk);
        checkOutput("tmo.len", txQ.size(), 32'd1);
        checkOutput("tmo.status", txAt(0), 32'h03);
        checkOutput("tmo.ferr", ferrCount - f0, 32'd1);
        checkOutput("tmo.pops", rdCount - r0, 32'd4);
        checkOutput("tmo.idle", {31'b0, o_busy}, 32'd0);

        // TX FIFO held full: nothing may be pushed, then the response drains in order.
        txQ.delete();
        i_tx_full = 1'b1;
        pushFrame(8'h20, 16'h1234, 16'h0010, 8'h00);
        wrSeen = 0;
        repeat (50) begin
            @(negedge i_clk);
            if (o_wr_uart) wrSeen++;
        end
        checkOutput("full.noWrite", wrSeen, 32'd0);
        checkOutput("full.busy", {31'b0, o_busy}, 32'd1);
        i_tx_full = 1'b0;
        waitDone(3, "full");
        checkOutput("full.len", txQ.size(), 32'd3);
        checkOutput("full.b0", txAt(0), 32'h00);
        checkOutput("full.b1", txAt(1), 32'h44);
        checkOutput("full.b2", txAt(2), 32'h12);

        // Reset in the middle of operand A discards the partial frame.
        txQ.delete();
        rxQ.push_back(8'hA5);
        rxQ.push_back(8'h20);
        rxQ.push_back(8'h34);
        cyc = 0;
        while (rxQ.size() > 0 && cyc < 50) begin
            @(negedge i_clk);
            cyc++;
        end
        checkOutput("midReset.busyBefore", {31'b0, o_busy}, 32'd1);
        i_reset = 1'b1;
        @(negedge i_clk);
        i_reset = 1'b0;
        checkOutput("midReset.busy", {31'b0, o_busy}, 32'd0);
        checkOutput("midReset.opA", {16'h0, o_op_a}, 32'd0);
        checkOutput("midReset.opc", {26'h0, o_op_code}, 32'd0);
        checkOutput("midReset.wr", {31'b0, o_wr_uart}, 32'd0);
        applyStimulus(8'h20, 16'h1234, 16'h0010, 8'h00, 8'h00, 16'h1244, "afterReset");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
